// File: rtl/blk_647c43.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle, signed or unsigned,
// returns quotient or remainder; the pipeline may abort an operation in flight.
module blk_647c43 #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] E_src1,
    input  logic [DATA_W-1:0] E_src2,
    input  logic              E_div_start,
    input  logic              E_div_signed,
    input  logic              E_div_rem,
    input  logic              M_div_abort,
    output logic              M_div_busy,
    output logic              M_div_done,
    output logic [DATA_W-1:0] M_div_result
);
    localparam int unsigned       CNT_W   = $clog2(DATA_W + 1);
    localparam logic [DATA_W-1:0] MIN_INT = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIXUP, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] src1_q, src1_d;
    logic [DATA_W-1:0] src2_q, src2_d;
    logic              sgn_q, sgn_d;
    logic              rem_sel_q, rem_sel_d;
    logic [DATA_W-1:0] dvd_q, dvd_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;
    logic              div0_q, div0_d;
    logic              ovf_q, ovf_d;

    logic              sign1, sign2;
    logic [DATA_W:0]   shifted;
    logic [DATA_W-1:0] q_fix, r_fix;

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        sgn_d     = sgn_q;
        rem_sel_d = rem_sel_q;
        dvd_d     = dvd_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        div0_d    = div0_q;
        ovf_d     = ovf_q;

        sign1   = sgn_q & src1_q[DATA_W-1];
        sign2   = sgn_q & src2_q[DATA_W-1];
        // One extra bit on the partial remainder so the compare never loses the carry
        shifted = {rem_q, dvd_q[DATA_W-1]};
        q_fix   = q_neg_q ? -dvd_q : dvd_q;
        r_fix   = r_neg_q ? -rem_q : rem_q;

        case (state_q)
            S_IDLE: begin
                if (E_div_start) begin
                    src1_d    = E_src1;
                    src2_d    = E_src2;
                    sgn_d     = E_div_signed;
                    rem_sel_d = E_div_rem;
                    busy_d    = 1'b1;
                    state_d   = S_PREP;
                end
            end
            S_PREP: begin
                if (M_div_abort) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    dvd_d   = sign1 ? -src1_q : src1_q;
                    dvs_d   = sign2 ? -src2_q : src2_q;
                    q_neg_d = sign1 ^ sign2;
                    r_neg_d = sign1;
                    rem_d   = '0;
                    cnt_d   = CNT_W'(DATA_W);
                    div0_d  = (src2_q == '0);
                    ovf_d   = sgn_q && (src1_q == MIN_INT) && (src2_q == '1);
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                if (M_div_abort) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    if (shifted >= {1'b0, dvs_q}) begin
                        rem_d = shifted[DATA_W-1:0] - dvs_q;
                        dvd_d = {dvd_q[DATA_W-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[DATA_W-1:0];
                        dvd_d = {dvd_q[DATA_W-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_FIXUP;
                    end
                end
            end
            S_FIXUP: begin
                if (M_div_abort) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    if (div0_q) begin
                        result_d = rem_sel_q ? src1_q : '1;
                    end else if (ovf_q) begin
                        result_d = rem_sel_q ? '0 : MIN_INT;
                    end else begin
                        result_d = rem_sel_q ? r_fix : q_fix;
                    end
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            sgn_q     <= 1'b0;
            rem_sel_q <= 1'b0;
            dvd_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            sgn_q     <= sgn_d;
            rem_sel_q <= rem_sel_d;
            dvd_q     <= dvd_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            div0_q    <= div0_d;
            ovf_q     <= ovf_d;
        end
    end

    assign M_div_busy   = busy_q;
    assign M_div_done   = done_q;
    assign M_div_result = result_q;

endmodule

// File: tb/tb_blk_647c43.sv
// Bench for blk_647c43: directed cases plus randomized operations against an
// arithmetic reference model, including start noise, abort and mid-operation reset.
module tb_blk_647c43;
    localparam int unsigned W   = 32;
    localparam int unsigned LAT = W + 3;

    logic          clk;
    logic          reset;
    logic [W-1:0]  E_src1;
    logic [W-1:0]  E_src2;
    logic          E_div_start;
    logic          E_div_signed;
    logic          E_div_rem;
    logic          M_div_abort;
    logic          M_div_busy;
    logic          M_div_done;
    logic [W-1:0]  M_div_result;

    int unsigned   n_checks;
    int unsigned   n_errors;
    logic [W-1:0]  last_exp;

    blk_647c43 #(.DATA_W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .E_src1       (E_src1),
        .E_src2       (E_src2),
        .E_div_start  (E_div_start),
        .E_div_signed (E_div_signed),
        .E_div_rem    (E_div_rem),
        .M_div_abort  (M_div_abort),
        .M_div_busy   (M_div_busy),
        .M_div_done   (M_div_done),
        .M_div_result (M_div_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Truncating division; remainder takes the dividend's sign.
    function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sgn, input logic rem);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 0) return rem ? a : 32'hFFFF_FFFF;
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
            return rem ? 32'(sa % sb) : 32'(sa / sb);
        end
        return rem ? (a % b) : (a / b);
    endfunction

    // Called at a negedge with the DUT idle; start is presented in "cycle 0".
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                          input logic rem, input logic abort_with_start, input logic noise,
                          input int unsigned abort_at, input int unsigned reset_at);
        logic [W-1:0] exp;
        int unsigned  c;
        bit           finished;
        exp = ref_div(a, b, sgn, rem);
        check("idle_busy", {31'b0, M_div_busy}, 32'h0);
        E_src1       = a;
        E_src2       = b;
        E_div_signed = sgn;
        E_div_rem    = rem;
        E_div_start  = 1'b1;
        M_div_abort  = abort_with_start;
        c = 0;
        finished = 0;
        while (!finished && c < LAT + 20) begin
            @(negedge clk);
            c++;
            E_div_start = 1'b0;
            M_div_abort = 1'b0;
            if (reset_at != 0 && c == reset_at + 1) begin
                reset = 1'b0;
                check("rst_busy", {31'b0, M_div_busy}, 32'h0);
                check("rst_done", {31'b0, M_div_done}, 32'h0);
                check("rst_result", M_div_result, 32'h0);
                last_exp = '0;
                finished = 1;
            end else if (abort_at != 0 && c == abort_at + 1) begin
                check("abort_busy", {31'b0, M_div_busy}, 32'h0);
                check("abort_done", {31'b0, M_div_done}, 32'h0);
                check("abort_result", M_div_result, last_exp);
                finished = 1;
            end else if (M_div_done) begin
                check("latency", c, LAT);
                check("result", M_div_result, exp);
                check("done_busy", {31'b0, M_div_busy}, 32'h1);
                last_exp = exp;
                finished = 1;
            end else begin
                check("busy", {31'b0, M_div_busy}, 32'h1);
                check("held", M_div_result, last_exp);
            end
            if (!finished) begin
                if (noise && (c == 3 || c == 20)) begin
                    E_div_start  = 1'b1;
                    E_src1       = $urandom;
                    E_src2       = $urandom;
                    E_div_signed = 1'($urandom);
                    E_div_rem    = 1'($urandom);
                end
                if (abort_at != 0 && c == abort_at) M_div_abort = 1'b1;
                if (reset_at != 0 && c == reset_at) reset = 1'b1;
            end
        end
        if (!finished) check("timeout", c, LAT);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        int unsigned  sel;
        clk          = 1'b0;
        reset        = 1'b1;
        E_src1       = '0;
        E_src2       = '0;
        E_div_start  = 1'b0;
        E_div_signed = 1'b0;
        E_div_rem    = 1'b0;
        M_div_abort  = 1'b0;
        n_checks     = 0;
        n_errors     = 0;
        last_exp     = '0;

        @(negedge clk);
        @(negedge clk);
        check("reset_busy", {31'b0, M_div_busy}, 32'h0);
        check("reset_done", {31'b0, M_div_done}, 32'h0);
        check("reset_result", M_div_result, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases
        run_op(32'd100, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);           @(negedge clk);
        run_op(-32'sd7, 32'd2, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);           @(negedge clk);
        run_op(-32'sd7, 32'd2, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);           @(negedge clk);
        run_op(32'd7, -32'sd2, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);           @(negedge clk);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);     @(negedge clk);
        run_op(32'd5, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);             @(negedge clk);
        run_op(32'd5, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);             @(negedge clk);
        run_op(-32'sd9, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);           @(negedge clk);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0); @(negedge clk);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0); @(negedge clk);
        run_op(32'd12345, 32'd67, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);        @(negedge clk);
        // Abort at cycle 10, then restart in cycle 12
        run_op(32'd999, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0, 10, 0);          @(negedge clk);
        run_op(32'd1000, 32'd9, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);          @(negedge clk);
        // Reset at cycle 15, then restart in cycle 17
        run_op(32'd77, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 0, 15);           @(negedge clk);
        run_op(-32'sd100, 32'd7, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);         @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = '0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = b >> $urandom_range(0, 31);
                4: a = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            run_op(a, b, 1'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0),
                   1'($urandom), 0, 0);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
